// File: rtl/sbox_disp_pkg.sv
// Shared types and constants for the S-box hex display: FSM states and the
// active-low {g,f,e,d,c,b,a} segment patterns for hex digits 0..F.
package sbox_disp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLASH  = 2'd1,
      STEADY = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment decode.
module hex_to_7seg
   import sbox_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sbox_hex_display.sv
// Two-digit multiplexed hex display of the captured S-box byte with LED mirror.
// Define SBOX_DISP_FLASH_EN to build the post-load flash sequence and busy flag.
module sbox_hex_display
   import sbox_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int FLASH_DIV   = 12500000,
   parameter int FLASH_COUNT = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] data_in,
   input  logic       encrypt,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [1:0] an_n,
   output logic [7:0] led,
   output logic       busy
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);

   if (REFRESH_DIV < 2 || FLASH_DIV < 2 || FLASH_COUNT < 2 || (FLASH_COUNT % 2) != 0) begin : g_param_check
      $error("sbox_hex_display: invalid divider or flash count parameters");
   end

   state_t        state;
   state_t        state_next;
   logic [7:0]    cap_byte;
   logic          cap_enc;
   logic [RW-1:0] scan_cnt;
   logic          scan_wrap;
   logic          digit_next;
   logic          blank;
   logic          show;
   logic [3:0]    nib;
   logic [6:0]    seg_dec;
   logic [6:0]    seg_p0;
   logic          dp_p0;
   logic [7:0]    led_p0;

   // Digit scan: free-running, never disturbed by load or state
   assign scan_wrap  = (scan_cnt == R_LAST);
   assign digit_next = an_n[0] ^ scan_wrap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_cnt <= '0;
         an_n     <= 2'b10;
      end else begin
         scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
         an_n     <= {~digit_next, digit_next};
      end
   end

`ifdef SBOX_DISP_FLASH_EN
   localparam int FW = $clog2(FLASH_DIV);
   localparam int PW = $clog2(FLASH_COUNT);
   localparam logic [FW-1:0] F_LAST = FW'(FLASH_DIV - 1);
   localparam logic [PW-1:0] P_LAST = PW'(FLASH_COUNT - 1);
   localparam state_t LOAD_STATE = FLASH;

   logic [FW-1:0] flash_cnt;
   logic [PW-1:0] phase_cnt;
   logic          flash_wrap;
   logic          last_phase;

   assign flash_wrap = (flash_cnt == F_LAST);
   assign last_phase = flash_wrap && (phase_cnt == P_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flash_cnt <= '0;
         phase_cnt <= '0;
      end else if (load) begin
         flash_cnt <= '0;
         phase_cnt <= '0;
      end else if (state == FLASH) begin
         flash_cnt <= flash_wrap ? '0 : flash_cnt + 1'b1;
         if (flash_wrap)
            phase_cnt <= last_phase ? '0 : phase_cnt + 1'b1;
      end
   end

   // Even phases are blank, so every flash sequence opens dark
   assign blank = (state == FLASH) && !phase_cnt[0];
   assign busy  = (state == FLASH);
`else
   localparam state_t LOAD_STATE = STEADY;

   assign blank = 1'b0;
   assign busy  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cap_byte <= 8'h00;
         cap_enc  <= 1'b0;
      end else begin
         state <= state_next;
         if (load) begin
            cap_byte <= data_in;
            cap_enc  <= encrypt;
         end
      end
   end

   // The decoder follows the digit that will be enabled alongside the registered segments
   assign nib = digit_next ? cap_byte[7:4] : cap_byte[3:0];

   hex_to_7seg u_hex_to_7seg (
      .nibble (nib),
      .seg    (seg_dec)
   );

   always_comb begin
      state_next = state;
      show       = 1'b0;
      seg_p0     = SEG_BLANK;
      dp_p0      = 1'b1;
      led_p0     = 8'h00;

      case (state)
         IDLE:    if (load) state_next = LOAD_STATE;
`ifdef SBOX_DISP_FLASH_EN
         FLASH: begin
            if (load)
               state_next = FLASH;
            else if (last_phase)
               state_next = STEADY;
         end
`endif
         STEADY:  if (load) state_next = LOAD_STATE;
         default: state_next = IDLE;
      endcase

      show = (state != IDLE) && !blank;
      if (show) begin
         seg_p0 = seg_dec;
         dp_p0  = !(digit_next && !cap_enc);
      end
      if (state_next != IDLE)
         led_p0 = load ? data_in : cap_byte;
   end

   // Output register stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_n <= SEG_BLANK;
         dp_n  <= 1'b1;
         led   <= 8'h00;
      end else begin
         seg_n <= seg_p0;
         dp_n  <= dp_p0;
         led   <= led_p0;
      end
   end

endmodule

// File: tb/tb_sbox_hex_display.sv
// Randomized self-checking bench for sbox_hex_display against a timeline model.
module tb_sbox_hex_display;

   localparam int R  = 4;
   localparam int FD = 8;
   localparam int FC = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       load = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       encrypt = 1'b0;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [1:0] an_n;
   logic [7:0] led;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0] hex_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   always #5 clk = ~clk;

   sbox_hex_display #(
      .REFRESH_DIV (R),
      .FLASH_DIV   (FD),
      .FLASH_COUNT (FC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .data_in (data_in),
      .encrypt (encrypt),
      .seg_n   (seg_n),
      .dp_n    (dp_n),
      .an_n    (an_n),
      .led     (led),
      .busy    (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: edge count since reset, the edge of the latest load and its data.
   // prev_* hold the same facts as they stood one edge earlier.
   int         e = 0;
   int         last_ld = 0;
   int         prev_last = 0;
   bit         loaded = 1'b0;
   bit         prev_loaded = 1'b0;
   logic [7:0] cap = 8'h00;
   logic [7:0] prev_cap = 8'h00;
   bit         enc = 1'b0;
   bit         prev_enc = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e           <= 0;
         loaded      <= 1'b0;
         prev_loaded <= 1'b0;
         last_ld     <= 0;
         cap         <= 8'h00;
         enc         <= 1'b0;
      end else begin
         prev_loaded <= loaded;
         prev_last   <= last_ld;
         prev_cap    <= cap;
         prev_enc    <= enc;
         e           <= e + 1;
         if (load) begin
            loaded  <= 1'b1;
            last_ld <= e + 1;
            cap     <= data_in;
            enc     <= encrypt;
         end
      end
   end

   function automatic bit in_flash(input bit ld, input int since);
`ifdef SBOX_DISP_FLASH_EN
      return ld && (since < FC * FD);
`else
      return 1'b0;
`endif
   endfunction

   always @(negedge clk) begin : compare
      int         dig;
      bit         shown;
      logic [3:0] nib;
      logic [6:0] exp_seg;
      bit         exp_dp;
      dig   = (e / R) % 2;
      shown = prev_loaded &&
              !(in_flash(prev_loaded, e - 1 - prev_last) && (((e - 1 - prev_last) / FD) % 2 == 0));
      nib     = dig ? prev_cap[7:4] : prev_cap[3:0];
      exp_seg = shown ? hex_tab[nib] : 7'h7F;
      exp_dp  = !(shown && dig == 1 && !prev_enc);
      check("cyc_seg_n", 32'(seg_n), 32'(exp_seg));
      check("cyc_dp_n", 32'(dp_n), 32'(exp_dp));
      check("cyc_an_n", 32'(an_n), (dig == 1) ? 'h1 : 'h2);
      check("cyc_led", 32'(led), loaded ? 32'(cap) : 'h0);
      check("cyc_busy", 32'(busy), 32'(in_flash(loaded, e - last_ld)));
   end

   // Called at a falling edge; returns at the falling edge after the capture edge.
   task automatic pulse_load(input logic [7:0] d, input logic en);
      load    = 1'b1;
      data_in = d;
      encrypt = en;
      @(negedge clk);
      load    = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (!busy) break;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_an(input logic [1:0] v);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3 * R; i++) begin
         if (an_n == v) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok)
         check("wait_an_timeout", 32'(an_n), 32'(v));
   endtask

   initial begin
      int n;
      #22 reset_n = 1'b1;
      check("rst_seg_n", 32'(seg_n), 'h7F);
      check("rst_dp_n", 32'(dp_n), 'h1);
      check("rst_an_n", 32'(an_n), 'h2);
      check("rst_led", 32'(led), 'h0);
      check("rst_busy", 32'(busy), 'h0);

      repeat (3) @(negedge clk);
      check("idle_an_first", 32'(an_n), 'h2);
      @(negedge clk);
      check("idle_an_toggle", 32'(an_n), 'h1);
      repeat (16) @(negedge clk);
      check("idle_seg_n", 32'(seg_n), 'h7F);
      check("idle_led", 32'(led), 'h0);

`ifdef SBOX_DISP_FLASH_EN
      pulse_load(8'h7C, 1'b0);
      count_busy(n);
      check("flash_len", n, 16);
      wait_an(2'b10);
      check("steady_d0_seg", 32'(seg_n), 'h46);
      check("steady_d0_dp", 32'(dp_n), 'h1);
      wait_an(2'b01);
      check("steady_d1_seg", 32'(seg_n), 'h78);
      check("steady_d1_dp", 32'(dp_n), 'h0);

      pulse_load(8'h7C, 1'b0);
      repeat (11) @(negedge clk);
      check("reflash_busy_before", 32'(busy), 'h1);
      pulse_load(8'h00, 1'b1);
      count_busy(n);
      check("reflash_len", n, 16);
      wait_an(2'b10);
      check("zero_d0_seg", 32'(seg_n), 'h40);
      wait_an(2'b01);
      check("zero_d1_seg", 32'(seg_n), 'h40);
      check("zero_d1_dp", 32'(dp_n), 'h1);

      pulse_load(8'hA5, 1'b1);
      repeat (15) @(negedge clk);
      check("expiry_busy_last", 32'(busy), 'h1);
      pulse_load(8'h5A, 1'b1);
      count_busy(n);
      check("expiry_reload_len", n, 16);
`else
      pulse_load(8'h63, 1'b1);
      check("direct_led", 32'(led), 'h63);
      check("direct_busy", 32'(busy), 'h0);
      wait_an(2'b10);
      check("direct_d0_seg", 32'(seg_n), 'h30);
      check("direct_d0_dp", 32'(dp_n), 'h1);
      wait_an(2'b01);
      check("direct_d1_seg", 32'(seg_n), 'h02);
      check("direct_d1_dp", 32'(dp_n), 'h1);
`endif

      pulse_load(8'hC3, 1'b0);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_seg_n", 32'(seg_n), 'h7F);
      check("midrst_dp_n", 32'(dp_n), 'h1);
      check("midrst_an_n", 32'(an_n), 'h2);
      check("midrst_led", 32'(led), 'h0);
      check("midrst_busy", 32'(busy), 'h0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("postrst_led", 32'(led), 'h0);
      check("postrst_busy", 32'(busy), 'h0);
      check("postrst_seg_n", 32'(seg_n), 'h7F);

      for (int i = 0; i < 1500; i++) begin
         load    = ($urandom_range(0, 11) == 0);
         data_in = 8'($urandom);
         encrypt = 1'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            load = 1'b0;
            #2 reset_n = 1'b0;
            #4 reset_n = 1'b1;
         end
         @(negedge clk);
      end
      load = 1'b0;
      repeat (40) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
